slt_sort4_sequencer: RTL and testbench
======================================

SLT_SORT4_SEQUENCER -- requirements
Module: slt_sort4_sequencer

Interface
REQ-001: Parameter DATA_W, default 32, signed word width of every data word and of the compare datapath.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: reset_n  input  1  reset, asynchronous, active-low.
REQ-004: in_valid  input  1  in_data holds a word offered for loading.
REQ-005: in_data  input  DATA_W  signed word to load.
REQ-006: in_ready  output  1  block accepts a word this cycle.
REQ-007: out_valid  output  1  out_data holds a sorted word.
REQ-008: out_data  output  DATA_W  sorted word, ascending signed order.
REQ-009: out_ready  input  1  consumer accepts out_data this cycle.
REQ-010: busy  output  1  high in SORT or DRAIN.
REQ-011: swap_count  output  3  number of swaps performed in the current or most recent sort, 0..6.

Function
REQ-012: The block SHALL hold four DATA_W registers r0..r3 and one shared compare unit; at most one compare SHALL occur per cycle.
REQ-013: Compare less(a,b) SHALL be computed as sign bit of (a-b) XOR signed overflow of (a-b), DATA_W-bit two's complement, never as a plain unsigned or sign-only test.
REQ-014: FSM states: LOAD, SORT, DRAIN; no other states.
REQ-015: LOAD: in_ready=1; a word transfers when in_valid&in_ready; words fill r0,r1,r2,r3 in arrival order via 2-bit load counter.
REQ-016: LOAD -> SORT on the cycle the 4th word transfers; in_ready SHALL be 0 outside LOAD.
REQ-017: SORT: six cycles, fixed schedule of pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1), one pair per cycle, 3-bit step counter 0..5.
REQ-018: For pair (i,j): if less(rj,ri) then swap ri,rj and increment swap_count; equal values SHALL NOT swap (stable).
REQ-019: SORT -> DRAIN after step 5; no early exit even when no swap occurs.
REQ-020: swap_count SHALL clear to 0 on the transition LOAD -> SORT and hold its value through DRAIN and the following LOAD.
REQ-021: DRAIN: out_valid=1, out_data = r[drain index]; index advances 0->3 on each out_valid&out_ready.
REQ-022: out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023: DRAIN -> LOAD on the transfer of r3; in_ready SHALL be 1 the following cycle, never the same cycle.
REQ-024: Latency: first out_valid SHALL assert exactly 7 cycles after the clock edge that accepts the 4th input word (6 SORT cycles + 1).
REQ-025: in_valid during SORT/DRAIN SHALL be ignored; out_ready outside DRAIN SHALL be ignored.
REQ-026: out_valid and busy SHALL be 0 in LOAD.

Reset
REQ-027: reset_n low SHALL immediately force state LOAD, all counters 0, r0..r3 = 0, swap_count = 0, out_valid = 0, busy = 0, out_data = 0, in_ready = 1 after release.
REQ-028: Reset asserted mid-LOAD, mid-SORT or mid-DRAIN SHALL discard all partial data; first word after release loads into r0.
REQ-029: Outputs SHALL be driven from registers or state decode only; no combinational path in_valid->in_ready or out_ready->out_valid.

Verification
REQ-030: Load 4,3,2,1 with out_ready=1 -> outputs 1,2,3,4, swap_count=6, first out_valid 7 cycles after 4th accept.
REQ-031: Load 0x7FFFFFFF,0x80000000,0,0xFFFFFFFF -> outputs 0x80000000,0xFFFFFFFF,0,0x7FFFFFFF (subtract-overflow case ordered correctly).
REQ-032: Load 5,5,5,5 then 1,2,3,4 back-to-back -> outputs 5,5,5,5 (swap_count=0) then 1,2,3,4 (swap_count=0); in_ready low throughout SORT/DRAIN.
REQ-033: DRAIN with out_ready toggling 0,1,0,0,1,... -> out_data held while stalled, each word delivered exactly once, in order.
REQ-034: Assert reset_n=0 on SORT step 3, release, load 9,8,7,6 -> outputs 6,7,8,9, no residue of prior data, swap_count=6.
REQ-035: in_valid held high during SORT and DRAIN -> no extra words loaded; next LOAD begins at r0.

Source files
------------

// File: rtl/slt_sort4_sequencer.sv
// Four-word signed sorter: load four words, run a fixed six-step compare/swap
// network through one shared comparator, then drain the words in ascending order.
module slt_sort4_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [2:0]        swap_count
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               load_cnt_q;
  logic [2:0]               step_q;
  logic [1:0]               drain_idx_q;
  logic [3:0][DATA_W-1:0]   r_q;
  logic [2:0]               swap_cnt_q;
  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_data_q;

  logic                     accept, last_load, last_step, deliver, last_out;
  logic [1:0]               pi, pj, nxt_idx;
  logic [DATA_W-1:0]        cmp_a, cmp_b, diff;
  logic                     ovf, do_swap;

  assign accept    = (state_q == LOAD) && in_valid;
  assign last_load = accept && (load_cnt_q == 2'd3);
  assign last_step = (state_q == SORT) && (step_q == 3'd5);
  assign deliver   = (state_q == DRAIN) && out_valid_q && out_ready;
  assign last_out  = deliver && (drain_idx_q == 2'd3);
  assign nxt_idx   = drain_idx_q + 2'd1;

  // Pair schedule (0,1),(1,2),(2,3),(0,1),(1,2),(0,1) indexed by step.
  always_comb begin
    pi = 2'd2;
    case (step_q)
      3'd0, 3'd3, 3'd5: pi = 2'd0;
      3'd1, 3'd4:       pi = 2'd1;
      default:          pi = 2'd2;
    endcase
  end
  assign pj = pi + 2'd1;

  // Signed less(b,a) = sign(b-a) ^ overflow(b-a); equal words never swap.
  assign cmp_a   = r_q[pi];
  assign cmp_b   = r_q[pj];
  assign diff    = cmp_b - cmp_a;
  assign ovf     = (cmp_b[MSB] ^ cmp_a[MSB]) & (diff[MSB] ^ cmp_b[MSB]);
  assign do_swap = (state_q == SORT) && (diff[MSB] ^ ovf);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LOAD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_load) state_d = SORT;
      SORT:    if (last_step) state_d = DRAIN;
      DRAIN:   if (last_out)  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LOAD);
    busy     = (state_q != LOAD);
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign swap_count = swap_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt_q  <= '0;
      step_q      <= '0;
      drain_idx_q <= '0;
      r_q         <= '0;
      swap_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        r_q[load_cnt_q] <= in_data;
        load_cnt_q      <= load_cnt_q + 2'd1;
        if (last_load) begin
          swap_cnt_q <= '0;
          step_q     <= '0;
        end
      end
      if (state_q == SORT) begin
        step_q <= last_step ? 3'd0 : step_q + 3'd1;
        if (do_swap) begin
          r_q[pi]    <= cmp_b;
          r_q[pj]    <= cmp_a;
          swap_cnt_q <= swap_cnt_q + 3'd1;
        end
      end
      // First DRAIN cycle primes the registered output with r0.
      if (state_q == DRAIN) begin
        if (!out_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= r_q[drain_idx_q];
        end else if (out_ready) begin
          drain_idx_q <= nxt_idx;
          if (drain_idx_q == 2'd3) out_valid_q <= 1'b0;
          else                     out_data_q  <= r_q[nxt_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_slt_sort4_sequencer.sv
// Directed bench for slt_sort4_sequencer: hand-computed sort results, latency,
// stall hold, reset recovery and input-ignore behaviour.
module tb_slt_sort4_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic [2:0]  swap_count;

  int n_chk = 0;
  int n_pass = 0;

  slt_sort4_sequencer #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Load four words, check latency, drain with optional stall pattern, check result.
  task automatic run(input string nm,
                     input logic [31:0] a, b, c, d,
                     input logic [31:0] e0, e1, e2, e3,
                     input logic [2:0] sc, input bit stall, input bit hold);
    logic [31:0] w[4];
    logic [31:0] ex[4];
    int k, n;
    bit seen, pv, pr;
    logic [31:0] pd;
    w = '{a, b, c, d};
    ex = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready word%0d: got %b exp 1", nm, i, in_ready);
      else n_pass++;
      in_valid = 1'b1;
      in_data  = w[i];
    end
    @(posedge clk); #1;
    if (hold) in_data = 32'd99;
    else in_valid = 1'b0;

    seen = 0; n = 0;
    for (int cy = 1; cy <= 20 && !seen; cy++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin seen = 1; n = cy; end
    end
    n_chk++;
    if (n != 7) $display("FAIL %s latency: got %0d exp 7", nm, n);
    else n_pass++;

    k = 0; pv = 0; pr = 0; pd = '0;
    for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
      @(negedge clk);
      out_ready = stall ? ((cyc % 5 == 1) || (cyc % 5 == 4)) : 1'b1;
      n_chk++;
      if (in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL %s drain_ctrl: in_ready=%b busy=%b exp 0/1", nm, in_ready, busy);
      else n_pass++;
      if (pv && !pr) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== pd)
          $display("FAIL %s stall_hold: got v=%b d=%h exp v=1 d=%h", nm, out_valid, out_data, pd);
        else n_pass++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_chk++;
        if (out_data !== ex[k]) $display("FAIL %s out%0d: got %h exp %h", nm, k, out_data, ex[k]);
        else n_pass++;
        k++;
        if (k == 4) in_valid = 1'b0;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
    end
    n_chk++;
    if (k != 4) $display("FAIL %s drain_count: got %0d words exp 4", nm, k);
    else n_pass++;

    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s post_drain: in_ready=%b out_valid=%b busy=%b exp 1/0/0", nm, in_ready, out_valid, busy);
    else n_pass++;
    n_chk++;
    if (swap_count !== sc) $display("FAIL %s swap_count: got %0d exp %0d", nm, swap_count, sc);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'd0 || swap_count !== 3'd0)
      $display("FAIL reset_outputs: v=%b busy=%b d=%h sc=%0d exp 0/0/0/0", out_valid, busy, out_data, swap_count);
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    run("basic", 32'd4, 32'd3, 32'd2, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4, 3'd6, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    run("overflow", 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF,
        32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 3'd4, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run("b2b_equal", 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 3'd0, 1'b0, 1'b0);
    run("b2b_sorted", 32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run("stall", 32'd20, 32'hFFFFFFF6, 32'd30, 32'hFFFFFFD8,
        32'hFFFFFFD8, 32'hFFFFFFF6, 32'd20, 32'd30, 3'd4, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_inputs();
    run("hold_in", 32'd3, 32'd1, 32'd2, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 3'd5, 1'b0, 1'b1);
    run("after_hold", 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFD, 32'd0,
        32'hFFFFFFFD, 32'hFFFFFFFD, 32'd0, 32'd7, 3'd2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk); in_valid = 1'b1; in_data = 32'd50;
    @(negedge clk); in_data = 32'd60;
    @(negedge clk); in_valid = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    run("mid_load", 32'd11, 32'hFFFFFFFE, 32'd7, 32'd0,
        32'hFFFFFFFE, 32'd0, 32'd7, 32'd11, 3'd4, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_sort();
    logic [31:0] w[4];
    w = '{32'd100, 32'h80000000, 32'd3, 32'd7};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = w[i];
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || swap_count !== 3'd0 || out_data !== 32'd0)
      $display("FAIL mid_sort_reset: busy=%b v=%b sc=%0d d=%h exp 0/0/0/0", busy, out_valid, swap_count, out_data);
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    run("mid_sort", 32'd9, 32'd8, 32'd7, 32'd6, 32'd6, 32'd7, 32'd8, 32'd9, 3'd6, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_ignore_inputs();
    test_reset_mid_load();
    test_reset_mid_sort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
